// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive buffer: capture FSM states and the stored entry layout.
package UART_MIKE_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic {RXF_IDLE, RXF_ACK} rxf_state_e;

  typedef struct packed {
    logic                       perr;
    logic [UART_DATA_WIDTH-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read port and occupancy count.
module uart_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  T            wr_data_i,
  input  logic        rd_en_i,
  output T            rd_data_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] count_o
);

  T            mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_fire, rd_fire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a write when the head is popped on the same edge.
  assign wr_fire = wr_en_i && (!full_o || rd_en_i);
  assign rd_fire = rd_en_i && !empty_o;

  // Storage is never reset, so the head is masked to zero while empty.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each held rx byte once, acknowledges it, and queues it with
// its parity status for a first-word-fall-through consumer.
module uart_rx_fifo
  import UART_MIKE_pkg::*;
#(
  parameter int  DATA_W = UART_DATA_WIDTH,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_flag,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              parity_error,
  output logic              rx_flag_clr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              ovf_clr
);

  rxf_state_e state_q;
  logic       rx_flag_clr_q;
  logic       overflow_q;
  logic       wr_en;
  rx_entry_t  wr_entry;
  rx_entry_t  head;

  assign wr_en         = (state_q == RXF_IDLE) && rx_flag;
  assign wr_entry.perr = parity_error;
  assign wr_entry.data = rx_data;

  assign rd_data     = head.data;
  assign rd_perr     = head.perr;
  assign rx_flag_clr = rx_flag_clr_q;
  assign overflow    = overflow_q;

  // Overflow set is written after the clear so a drop on the same edge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RXF_IDLE;
      rx_flag_clr_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (ovf_clr) overflow_q <= 1'b0;
      case (state_q)
        RXF_IDLE: begin
          if (rx_flag) begin
            state_q       <= RXF_ACK;
            rx_flag_clr_q <= 1'b1;
            if (full && !rd_en) overflow_q <= 1'b1;
          end
        end
        RXF_ACK: begin
          if (!rx_flag) begin
            state_q       <= RXF_IDLE;
            rx_flag_clr_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= RXF_IDLE;
          rx_flag_clr_q <= 1'b0;
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .T     (rx_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

endmodule
